// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer.
package store_buffer_pkg;

    localparam int unsigned SB_DEPTH_DEF = 4;
    localparam int unsigned SB_AW        = 32;
    localparam int unsigned SB_WORD_LSB  = 2;
    localparam int unsigned SB_MATCH_W   = SB_AW - SB_WORD_LSB;

    typedef struct packed {
        logic [SB_AW-1:0] addr;
        logic [SB_AW-1:0] data;
    } sb_entry_t;

    // Word-granular address compare; byte-offset bits are ignored.
    function automatic logic sb_word_match(input logic [SB_AW-1:0] a, input logic [SB_AW-1:0] b);
        return a[SB_AW-1:SB_WORD_LSB] == b[SB_AW-1:SB_WORD_LSB];
    endfunction

endpackage

// File: rtl/sb_match.sv
// Youngest-first store-to-load forwarding lookup over the buffered entries.
// Lookup logic exists only when STORE_BUFFER_FWD_EN is defined; otherwise
// the outputs are tied to zero.
module sb_match
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH_DEF,
    parameter int unsigned AW    = SB_AW
) (
    input  sb_entry_t                i_entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] i_rd_ptr,
    input  logic [$clog2(DEPTH):0]   i_count,
    input  logic [AW-1:0]            i_ld_addr,
    output logic                     o_hit,
    output logic [AW-1:0]            o_data
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

`ifdef STORE_BUFFER_FWD_EN
    logic [PW-1:0] w_idx;

    // Walk entries oldest to youngest; a later match overrides an earlier one.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            w_idx = i_rd_ptr + PW'(k);
            if ((CW'(k) < i_count) &&
                sb_word_match(i_entries[w_idx].addr, SB_AW'(i_ld_addr))) begin
                o_hit  = 1'b1;
                o_data = AW'(i_entries[w_idx].data);
            end
        end
    end
`else
    logic [SB_AW-1:0] w_unused_fold;

    // Inputs are intentionally ignored when forwarding is compiled out.
    always_comb begin
        w_unused_fold = SB_AW'(i_ld_addr) ^ SB_AW'({i_rd_ptr, i_count});
        for (int unsigned k = 0; k < DEPTH; k++) begin
            w_unused_fold = w_unused_fold ^ i_entries[k].addr ^ i_entries[k].data;
        end
    end

    assign o_hit  = 1'b0;
    assign o_data = '0;
`endif

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer: FIFO of {addr, data} draining to a write bus, with
// optional load forwarding (define STORE_BUFFER_FWD_EN to enable).
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH_DEF,
    parameter int unsigned AW    = SB_AW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   st_valid,
    input  logic [AW-1:0]          st_addr,
    input  logic [AW-1:0]          st_data,
    output logic                   st_ready,
    input  logic [AW-1:0]          ld_addr,
    output logic                   ld_hit,
    output logic [AW-1:0]          ld_data,
    output logic                   mem_we,
    output logic [AW-1:0]          mem_addr,
    output logic [AW-1:0]          mem_data,
    input  logic                   mem_ready,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    sb_entry_t     r_entries [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = st_valid && !w_full;
    assign w_pop   = !w_empty && mem_ready;

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
        end
    end

    // Entry storage; validity comes from the pointers and count, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_entries[r_wr_ptr] <= '{addr: SB_AW'(st_addr), data: SB_AW'(st_data)};
        end
    end

    // Head outputs are masked by empty so reset forces them to zero at once.
    assign st_ready = !w_full;
    assign empty    = w_empty;
    assign count    = r_count;
    assign mem_we   = !w_empty;
    assign mem_addr = w_empty ? '0 : AW'(r_entries[r_rd_ptr].addr);
    assign mem_data = w_empty ? '0 : AW'(r_entries[r_rd_ptr].data);

    sb_match #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_match (
        .i_entries (r_entries),
        .i_rd_ptr  (r_rd_ptr),
        .i_count   (r_count),
        .i_ld_addr (ld_addr),
        .o_hit     (ld_hit),
        .o_data    (ld_data)
    );

endmodule
